// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - multiplexed 6-digit MM.SS.hh display driver with framed BCD conversion
module stopwatch_display #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       Clk_50Mhz,
  input  logic       Rst_n,
  input  logic [6:0] MiliSecSW,
  input  logic [5:0] SecSW,
  input  logic [6:0] MinSW,
  input  logic       BlinkSW,
  output logic [6:0] SegOut,
  output logic       DpOut,
  output logic [5:0] AnodeOut
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;

  logic [SCW-1:0] scan_cnt;
  logic [2:0]     digit_idx;
  logic [2:0]     next_idx;
  logic           scan_tick;
  logic           frame_start;

  state_t         state;
  logic [6:0]     work;
  logic [6:0]     snap_sec;
  logic [6:0]     snap_min;
  logic [3:0]     tens;
  logic [1:0]     field;
  logic [3:0]     conv [6];
  logic [3:0]     disp [6];

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign scan_tick   = (scan_cnt == SCAN_LAST);
  assign next_idx    = (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
  assign frame_start = scan_tick && (digit_idx == 3'd5);

  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_tick) begin
      scan_cnt  <= '0;
      digit_idx <= next_idx;
    end else begin
      scan_cnt  <= scan_cnt + SCW'(1);
    end
  end

  // Snapshot once per frame, convert by repeated subtraction, publish all six digits at once.
  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      work     <= '0;
      snap_sec <= '0;
      snap_min <= '0;
      tens     <= '0;
      field    <= '0;
      for (int i = 0; i < 6; i++) begin
        conv[i] <= '0;
        disp[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) state <= LOAD;
        end
        LOAD: begin
          work     <= clamp99(MiliSecSW);
          snap_sec <= clamp99({1'b0, SecSW});
          snap_min <= clamp99(MinSW);
          tens     <= '0;
          field    <= '0;
          state    <= CONV;
        end
        CONV: begin
          if (work >= 7'd10) begin
            work <= work - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            conv[{field, 1'b0}] <= work[3:0];
            conv[{field, 1'b1}] <= tens;
            tens <= '0;
            if (field == 2'd2) begin
              state <= COMMIT;
            end else begin
              field <= field + 2'd1;
              work  <= (field == 2'd0) ? snap_sec : snap_min;
            end
          end
        end
        COMMIT: begin
          for (int i = 0; i < 6; i++) disp[i] <= conv[i];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!BlinkSW) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BCW'(1);
    end
  end

  // Outputs show the digit being switched to on this tick.
  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      SegOut   <= 7'h7F;
      DpOut    <= 1'b1;
      AnodeOut <= 6'h3F;
    end else if (scan_tick) begin
      SegOut   <= seg_code(disp[next_idx]);
      AnodeOut <= blink_phase ? 6'h3F : ~(6'd1 << next_idx);
      DpOut    <= blink_phase | ~((next_idx == 3'd2) || (next_idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - scoreboard bench for stopwatch_display against an arithmetic display model
module tb_stopwatch_display;
  localparam int S  = 64;
  localparam int BD = 150;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] ms    = 7'd56;
  logic [5:0] sec   = 6'd34;
  logic [6:0] mn    = 7'd12;
  logic       blink = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  stopwatch_display #(.SCAN_DIV(S), .BLINK_DIV(BD)) dut (
    .Clk_50Mhz(clk), .Rst_n(rst_n), .MiliSecSW(ms), .SecSW(sec), .MinSW(mn),
    .BlinkSW(blink), .SegOut(seg), .DpOut(dp), .AnodeOut(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
  } exp_t;

  localparam exp_t RST_EXP = '{seg: 7'h7F, dp: 1'b1, an: 6'h3F};

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  exp_t q[$];
  exp_t cur = RST_EXP;
  int   total = 0;
  int   bad = 0;

  // Model state: edges since reset release, displayed field values, blink start edge.
  int   e = 0;
  int   d_ms = 0, d_sec = 0, d_min = 0;
  bit   blink_on = 0;
  int   bstart = 0;

  function automatic void chk(string nm, exp_t x);
    total++;
    if (seg !== x.seg || dp !== x.dp || an !== x.an) begin
      bad++;
      $display("FAIL %s t=%0t seg=%h exp=%h dp=%b exp=%b an=%h exp=%h",
               nm, $time, seg, x.seg, dp, x.dp, an, x.an);
    end
  endfunction

  function automatic int clampv(int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic exp_t expect_digit(int k, bit ph);
    exp_t x;
    int d, f, v;
    d = k % 6;
    f = (d / 2 == 0) ? d_ms : (d / 2 == 1) ? d_sec : d_min;
    v = (d % 2 == 0) ? f % 10 : f / 10;
    x.seg = segtab[v];
    x.an  = ph ? 6'h3F : ~(6'd1 << d);
    x.dp  = ph ? 1'b1 : !(d == 2 || d == 4);
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; d_ms = 0; d_sec = 0; d_min = 0;
      blink_on = 0; bstart = 0;
      q.delete();
      cur = RST_EXP;
    end else begin
      bit ph;
      e++;
      ph = blink_on ? (((e - bstart) / BD) % 2 == 1) : 1'b0;
      if (e % S == 0) q.push_back(expect_digit(e / S, ph));
      if (e % S == 1 && (e / S) % 6 == 0 && e / S > 0) begin
        d_ms  = clampv(int'(ms));
        d_sec = clampv(int'(sec));
        d_min = clampv(int'(mn));
      end
      if (!blink) blink_on = 0;
      else if (!blink_on) begin
        blink_on = 1;
        bstart = e;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) cur = q.pop_front();
      chk("scan_out", cur);
    end
  end

  task automatic wait_phase(input int off, input string nm);
    bit hit;
    hit = 0;
    for (int i = 0; i < 6 * S + 2; i++) begin
      @(negedge clk);
      if (e >= 6 * S && e % (6 * S) == off) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s wait expired e=%0d required offset=%0d", nm, e, off);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", RST_EXP);
    end
    rst_n = 1'b1;
    run(3 * 6 * S);

    ms = 7'd127; mn = 7'd100;
    run(2 * 6 * S);

    ms = 7'd56; mn = 7'd12; sec = 6'd34;
    run(6 * S);
    wait_phase(3 * S + 10, "mid_frame");
    sec = 6'd35;
    run(2 * 6 * S);

    blink = 1'b1;
    run(3 * 6 * S);
    blink = 1'b0;
    run(6 * S);

    for (int i = 0; i < 12 * 6 * S; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) ms  = 7'($urandom_range(127));
      if ($urandom_range(7) == 0) sec = 6'($urandom_range(63));
      if ($urandom_range(7) == 0) mn  = 7'($urandom_range(127));
      if ($urandom_range(299) == 0) blink = ~blink;
    end
    blink = 1'b0;
    run(6 * S);

    wait_phase(4, "conv_reset");
    #1 rst_n = 1'b0;
    #1 chk("reset_async", RST_EXP);
    ms = 7'd98; sec = 6'd7; mn = 7'd45;
    run(2);
    chk("reset_low", RST_EXP);
    rst_n = 1'b1;
    run(2 * 6 * S + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
